inst_cache: RTL and testbench
=============================

# inst_cache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory. It serves hits combinationally in the request cycle and refills missed lines one word per cycle from the memory's asynchronous read port. It drives the memory's byte address and consumes its 32-bit instruction output. It also keeps hit and miss counters for the cache lab's performance report.

## Interface
- `LINE_WORDS`, 4: words per line; power of two, at least 2.
- `NUM_SETS`, 16: number of lines; power of two.
- `reset`  in  1  synchronous, active-high.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `is_input_valid`  in  1  fetch request present.
- `addr`  in  32  byte address of the requested instruction; bits [1:0] are ignored.
- `is_ready`  out  1  cache is in IDLE and can take a request.
- `is_output_valid`  out  1  `dout` holds the requested instruction this cycle.
- `dout`  out  32  instruction word.
- `is_hit`  out  1  the current request hits.
- `mem_addr`  out  32  byte address sent to the instruction memory.
- `mem_dout`  in  32  word returned asynchronously by the memory for `mem_addr`.
- `hit_count`  out  32  number of hits since reset.
- `miss_count`  out  32  number of misses since reset.

## Operation
- Address split:
  - word offset `WO = log2(LINE_WORDS)` bits at [WO+1:2];
  - index `IX = log2(NUM_SETS)` bits directly above the word offset;
  - tag is every remaining upper bit.
- Per-line storage: one valid bit, the tag, and `LINE_WORDS` 32-bit data words. There is no dirty bit and no write path.
- FSM state IDLE:
  - `is_ready` = 1.
  - A request hits when `is_input_valid` is high, the indexed line is valid, and its tag matches. On a hit, in the same cycle: `is_hit` = 1, `is_output_valid` = 1, `dout` = the indexed data word.
  - A miss drives `is_output_valid` = 0. On the next edge: latch the tag and index, set fill counter `cnt` = 0, go to FILL.
- FSM state FILL:
  - `is_ready` = 0; `is_output_valid` = 0.
  - `mem_addr` = {latched tag, latched index, `cnt`, 2'b00}.
  - Each edge writes `mem_dout` into data word `cnt` of the line and increments `cnt`.
  - On the edge that writes word `LINE_WORDS-1`: set the valid bit, write the tag, return to IDLE.
- The requester must hold `addr` and `is_input_valid` stable until `is_output_valid` is seen. After a fill, the held request hits in IDLE.
- Outside FILL, `mem_addr` = `addr` with bits [1:0] cleared. It has no effect on the memory.
- `dout` = 0 whenever `is_output_valid` is 0.
- Counters:
  - `hit_count` increments on every IDLE cycle that has a valid request and a hit.
  - `miss_count` increments once per miss, on the IDLE→FILL edge.
  - Both wrap from 2^32−1 to 0.
  - A refilled request's follow-up hit also increments `hit_count`, so each miss adds one miss and one hit.

## Timing
- Reset: all valid bits cleared, state IDLE, `cnt` = 0, both counters 0. Outputs after reset: `is_ready` = 1, `is_output_valid` = 0, `is_hit` = 0, `dout` = 0.
- Hit latency: 0 cycles, combinational within the request cycle.
- Miss latency: the request is presented in cycle t. FILL occupies t+1 … t+LINE_WORDS. The hit is served in cycle t+LINE_WORDS+1, which is 5 cycles after the request with the default parameters.
- A new request may be presented in the cycle after a hit; back-to-back hits sustain one per cycle.
- If `is_input_valid` drops during FILL, the fill still completes and the line is validated. No output is produced for it.
- Reset asserted mid-FILL: the fill aborts, the line stays invalid, and everything returns to reset values on that edge.
- Index conflict: a line refilled with a new tag replaces the old one; the old tag misses afterwards.
- Data words are not cleared at reset. Valid gating guarantees stale data is never output.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, FILL;
  - derived widths `WO`, `IX`, and `TAG_W` = 32−IX−WO−2.
- One natural sub-module, `inst_cache_array`: valid/tag/data storage with a combinational read port and a single-word write port plus a tag/valid write strobe. The FSM, counters, and address mux stay in `inst_cache`.

## Test plan
- Cold miss, default parameters: after reset, request `addr` 0x00 with memory word 0 = 0x00500093. Required: `is_output_valid` low for cycles 0–4; `mem_addr` sequence 0x0, 0x4, 0x8, 0xC; hit at cycle 5 with `dout` = 0x00500093; `miss_count` = 1, `hit_count` = 1.
- Spatial locality: after the cold fill, requests to 0x4, 0x8, 0xC in consecutive cycles each hit the same cycle; `hit_count` = 4.
- Conflict eviction: 0x000 then 0x100 (same index, different tag) both miss. Re-requesting 0x000 misses again; final `miss_count` = 3.
- Reset mid-fill: assert `reset` at fill cycle 2 of 0x40. Afterwards `is_ready` = 1 and counters are 0; re-requesting 0x40 misses with a full 4-cycle fill.
- Requester drop: drop `is_input_valid` during the fill of 0x80. The fill still completes; a later 0x84 request hits immediately.
- Counter wrap: force `hit_count` to 0xFFFFFFFF and perform one hit → `hit_count` = 0.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived address-field widths and the controller state encoding.
package inst_cache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_NUM_SETS   = 16;

  localparam int WO    = $clog2(DEF_LINE_WORDS);
  localparam int IX    = $clog2(DEF_NUM_SETS);
  localparam int TAG_W = 32 - IX - WO - 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } cache_state_e;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the instruction cache: one combinational read port,
// a single-word write port and a tag/valid write strobe used on the last refill word.
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS,
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int IDX_W      = $clog2(NUM_SETS),
  parameter int TAGW       = 32 - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_index_i,
  input  logic [OFF_W-1:0] rd_word_i,
  output logic             rd_valid_o,
  output logic [TAGW-1:0]  rd_tag_o,
  output logic [31:0]      rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [OFF_W-1:0] wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic             wr_tag_en_i,
  input  logic [TAGW-1:0]  wr_tag_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAGW-1:0]     tag_q  [NUM_SETS];
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

  // Only the valid bits are reset; stale tags and data are hidden behind them.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_tag_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_tag_en_i) begin
      tag_q[wr_index_i] <= wr_tag_i;
    end
    if (!reset && wr_en_i) begin
      data_q[wr_index_i][wr_word_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits in IDLE, word-per-cycle
// line refill from an asynchronous memory in FILL, plus free-running hit/miss counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic [31:0] addr,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic [31:0] dout,
  output logic        is_hit,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAGW  = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  cache_state_e     state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [TAGW-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      hit_count_q, hit_count_d;
  logic [31:0]      miss_count_q, miss_count_d;

  logic [TAGW-1:0]  req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_word;
  logic             line_valid;
  logic [TAGW-1:0]  line_tag;
  logic [31:0]      line_data;
  logic             hit;
  logic             fill_last;

  assign req_tag  = addr[31 -: TAGW];
  assign req_idx  = addr[OFF_W+2 +: IDX_W];
  assign req_word = addr[2 +: OFF_W];

  assign hit       = (state_q == IDLE) && is_input_valid && line_valid && (line_tag == req_tag);
  assign fill_last = (state_q == FILL) && (cnt_q == LAST_WORD);

  inst_cache_array #(
    .LINE_WORDS (LINE_WORDS),
    .NUM_SETS   (NUM_SETS),
    .OFF_W      (OFF_W),
    .IDX_W      (IDX_W),
    .TAGW       (TAGW)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_index_i  (req_idx),
    .rd_word_i   (req_word),
    .rd_valid_o  (line_valid),
    .rd_tag_o    (line_tag),
    .rd_data_o   (line_data),
    .wr_en_i     (state_q == FILL),
    .wr_index_i  (idx_q),
    .wr_word_i   (cnt_q),
    .wr_data_i   (mem_dout),
    .wr_tag_en_i (fill_last),
    .wr_tag_i    (tag_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tag_q        <= '0;
      idx_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // The missed tag/index are latched so the refill is independent of the requester.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          hit_count_d = hit_count_q + 32'd1;
        end else if (is_input_valid) begin
          state_d      = FILL;
          cnt_d        = '0;
          tag_d        = req_tag;
          idx_d        = req_idx;
          miss_count_d = miss_count_q + 32'd1;
        end
      end
      FILL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_ready        = (state_q == IDLE);
  assign is_output_valid = hit;
  assign is_hit          = hit;
  assign dout            = hit ? line_data : 32'd0;
  assign mem_addr        = (state_q == FILL) ? {tag_q, idx_q, cnt_q, 2'b00} : (addr & ~32'h3);
  assign hit_count       = hit_count_q;
  assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with an asynchronous instruction-memory
// model; covers cold miss, locality, conflict eviction, reset mid-fill, requester drop, wrap.
module tb_inst_cache;

  localparam int LW = 4;

  logic        clk;
  logic        reset;
  logic        is_input_valid;
  logic [31:0] addr;
  logic        is_ready;
  logic        is_output_valid;
  logic [31:0] dout;
  logic        is_hit;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int passCount  = 0;
  int checkCount = 0;

  inst_cache #(.LINE_WORDS(LW), .NUM_SETS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_addr        (mem_addr),
    .mem_dout        (mem_dout),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (32'hC0DE_0000 + a);
  endfunction

  assign mem_dout = memWord(mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a);
    is_input_valid = v;
    addr           = a;
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input bit expMiss);
    tick();
    applyStimulus(1'b1, a);
    if (expMiss) begin
      checkOutput("missNoValid", {31'd0, is_output_valid}, 32'd0);
      checkOutput("missAddr", mem_addr, a & ~32'h3);
      for (int k = 0; k < LW; k++) begin
        tick();
        checkOutput("fillAddr", mem_addr, (a & ~32'hF) + 32'(4 * k));
        checkOutput("fillNoValid", {31'd0, is_output_valid}, 32'd0);
        checkOutput("fillBusy", {31'd0, is_ready}, 32'd0);
      end
      tick();
    end
    checkOutput("hitValid", {31'd0, is_output_valid}, 32'd1);
    checkOutput("hitFlag", {31'd0, is_hit}, 32'd1);
    checkOutput("hitData", dout, memWord(a & ~32'h3));
  endtask

  task automatic idle();
    tick();
    applyStimulus(1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rstReady", {31'd0, is_ready}, 32'd1);
    checkOutput("rstOutValid", {31'd0, is_output_valid}, 32'd0);
    checkOutput("rstHit", {31'd0, is_hit}, 32'd0);
    checkOutput("rstDout", dout, 32'd0);
    checkOutput("rstHitCnt", hit_count, 32'd0);
    checkOutput("rstMissCnt", miss_count, 32'd0);

    // Cold miss on 0x00, then its follow-up hit is counted.
    fetch(32'h0, 1'b1);
    idle();
    checkOutput("coldMissCnt", miss_count, 32'd1);
    checkOutput("coldHitCnt", hit_count, 32'd1);

    // Spatial locality: rest of the line hits back to back.
    fetch(32'h4, 1'b0);
    fetch(32'h8, 1'b0);
    fetch(32'hC, 1'b0);
    idle();
    checkOutput("localHitCnt", hit_count, 32'd4);
    checkOutput("localMissCnt", miss_count, 32'd1);

    // Conflict: 0x100 evicts 0x000 from set 0.
    fetch(32'h100, 1'b1);
    fetch(32'h000, 1'b1);
    idle();
    checkOutput("conflictMissCnt", miss_count, 32'd3);
    checkOutput("conflictHitCnt", hit_count, 32'd6);

    // Reset during the fill of 0x40.
    tick();
    applyStimulus(1'b1, 32'h40);
    tick();
    tick();
    checkOutput("midFillAddr", mem_addr, 32'h44);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("abortReady", {31'd0, is_ready}, 32'd1);
    checkOutput("abortNoHit", {31'd0, is_output_valid}, 32'd0);
    checkOutput("abortHitCnt", hit_count, 32'd0);
    checkOutput("abortMissCnt", miss_count, 32'd0);
    applyStimulus(1'b0, 32'h0);
    fetch(32'h40, 1'b1);
    idle();
    checkOutput("refillMissCnt", miss_count, 32'd1);
    checkOutput("refillHitCnt", hit_count, 32'd1);

    // Requester drops its request while 0x80 is being filled.
    tick();
    applyStimulus(1'b1, 32'h80);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("dropFillAddr0", mem_addr, 32'h80);
    for (int k = 1; k < LW; k++) begin
      tick();
      checkOutput("dropFillAddr", mem_addr, 32'h80 + 32'(4 * k));
      checkOutput("dropNoValid", {31'd0, is_output_valid}, 32'd0);
    end
    tick();
    checkOutput("dropReady", {31'd0, is_ready}, 32'd1);
    checkOutput("dropNoValidIdle", {31'd0, is_output_valid}, 32'd0);
    fetch(32'h84, 1'b0);
    idle();
    checkOutput("dropMissCnt", miss_count, 32'd2);
    checkOutput("dropHitCnt", hit_count, 32'd2);

    // Hit counter wraps from all-ones to zero.
    force dut.hit_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count_q;
    #1;
    checkOutput("wrapPreset", hit_count, 32'hFFFF_FFFF);
    fetch(32'h88, 1'b0);
    idle();
    checkOutput("wrapHitCnt", hit_count, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
